axi_mst128_cmd: RTL and testbench
=================================

// Module: axi_mst128_cmd
// PURPOSE
//  AXI4 128-bit initiator that turns a simple command/data stream into INCR bursts on the _s1 slave channels.
//  Feeds test slaves and memory/error-responder models on the CPU-side interconnect.
//  Handles one transaction at a time; returns read beats and one completion per command.
// PARAMETERS
//  ADDR_W  40     address width of cmd_addr/araddr_s1/awaddr_s1
//  AXI_ID  8'h01  ID driven on arid_s1/awid_s1/wid_s1; expected back on rid_s1/bid_s1
// PORTS
//  pll_core_cpuclk  in   1       sole clock, rising edge
//  pad_cpu_rst_b    in   1       async active-low reset
//  cmd_vld/cmd_rdy  in/out 1     command handshake
//  cmd_wr           in   1       1=write, 0=read
//  cmd_addr         in   ADDR_W  start address, 16B aligned (addr[3:0] ignored, driven as 0)
//  cmd_len          in   8       beats-1
//  wdat_vld/wdat_rdy in/out 1    write-data stream handshake
//  wdat/wdat_strb   in   128/16  write beat data/strobes
//  rdat_vld         out  1       read beat valid (no backpressure)
//  rdat/rdat_last   out  128/1   read beat data; last beat flag
//  done_vld         out  1       one-cycle completion pulse
//  done_resp        out  2       worst response of the transaction
//  done_perr        out  1       protocol error (ID or beat-count mismatch)
//  err_vld/err_addr out  1/ADDR_W  first-error log (see CONFIGURATION)
//  err_clr          in   1       clears error log
//  AXI _s1 set      ar*/r*/aw*/w*/b* (40b addr, 8b id/len, 3b size, 2b burst, 4b cache, 3b prot, 128b data, 16b strb)
// BEHAVIOUR
//  Reset: state IDLE; all *valid_s1, rready_s1, bready_s1, cmd_rdy, wdat_rdy, rdat_vld, done_vld, done_perr,
//    err_vld = 0; done_resp = 0; addr/len/id outputs = 0.
//  Fixed attrs: size=3'b100, burst=2'b01, cache=4'b0011, prot=3'b000.
//  FSM IDLE->AR->R->IDLE (read); IDLE->AW->W->B->IDLE (write).
//   IDLE: cmd_rdy=1; cmd_vld latches cmd_wr/addr/len, clears beat counter and resp accumulator.
//   AR/AW: valid held with stable fields until ready; then R / W next cycle.
//   R: rready_s1=1; each rvalid beat -> registered rdat/rdat_last/rdat_vld next cycle; beat cnt++;
//      resp accumulator = max(acc, rresp_s1). Exits on beat with rlast_s1=1.
//   W: wvalid_s1=wdat_vld, wdat_rdy=wready_s1 (comb passthrough); wlast_s1=(cnt==len);
//      exits after last beat handshake.
//   B: bready_s1=1; exits on bvalid_s1; acc=bresp_s1.
//   Completion: done_vld pulses cycle after final R/B handshake; cmd_rdy returns same cycle as done_vld.
//  Latency: cmd accept -> arvalid_s1/awvalid_s1 high next cycle; rdat_vld 1 cycle after R handshake.
//  done_perr=1 if rid/bid != AXI_ID, rlast early (cnt<len) or late (cnt==len and rlast=0 continues
//    until rlast; beats past len still forwarded). Counter is 8-bit; len=255 -> 256 beats, no wrap error.
//  Arbitrary AR/AW/R/W/B stalls legal; no combinational path from ready to valid on AR/AW.
//  Async reset mid-burst: all valids drop immediately; counters/accumulator cleared; no done_vld.
// CONFIGURATION
//  AXI_MST128_ERR_LOG_EN defined: on done with done_resp[1]=1 and err_vld=0, set err_vld, latch
//    err_addr=cmd start address; err_clr clears err_vld (err_clr wins over same-cycle set).
//  Undefined: err_vld=0, err_addr=0 constant; err_clr ignored; ports remain.
// TESTING
//  Read len=0 addr=0x1000, slave rdata=0xA5..A5 OKAY -> one rdat_vld, rdat_last=1, done_resp=00, perr=0.
//  Write len=3 addr=0x2030, 4 beats, random wready stalls -> wlast only on 4th beat, done_resp=bresp.
//  Read len=3 from slave returning rresp=2'b10 zero data -> 4 beats, done_resp=10; ERR_LOG_EN: err_addr=addr.
//  Slave returns rid=8'h02 -> done_perr=1; rlast on beat 2 of len=3 -> done_perr=1, FSM back to IDLE.
//  Assert pad_cpu_rst_b low mid write burst -> valids 0 same cycle, no done_vld; next cmd completes normally.
//  err_clr and new error done in same cycle -> err_vld=0 after edge.

Source files
------------

// File: rtl/axi_mst128_cmd.sv
// AXI4 128-bit initiator: one command in, one INCR burst out on the _s1 channels, one completion back.
// Latency: cmd accept -> AR/AW valid next cycle; R beat -> rdat_vld next cycle; final R/B handshake -> done_vld next cycle.
// Backpressure: cmd_rdy only in IDLE; W data is a combinational wdat<->W passthrough; rdat/done have no backpressure.
//
// Ports
//   pll_core_cpuclk / pad_cpu_rst_b : clock (rising edge) / async active-low reset
//   cmd_*   : command handshake (cmd_wr, cmd_addr 16B aligned, cmd_len = beats-1)
//   wdat_*  : write beat stream, passed straight to the W channel while bursting
//   rdat_*  : registered read beats (no backpressure), rdat_last marks the beat carrying rlast
//   done_*  : one-cycle completion pulse with worst response and protocol-error flag
//   err_*   : first-error log; only active when AXI_MST128_ERR_LOG_EN is defined, otherwise tied to 0
//   ar*/r*/aw*/w*/b* _s1 : AXI4 initiator channels (fixed 16B INCR, cache 4'b0011, prot 0)
module axi_mst128_cmd #(
    parameter int          ADDR_W = 40,
    parameter logic [7:0]  AXI_ID = 8'h01
) (
    input  logic                pll_core_cpuclk,
    input  logic                pad_cpu_rst_b,

    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,

    input  logic                wdat_vld,
    output logic                wdat_rdy,
    input  logic [127:0]        wdat,
    input  logic [15:0]         wdat_strb,

    output logic                rdat_vld,
    output logic [127:0]        rdat,
    output logic                rdat_last,

    output logic                done_vld,
    output logic [1:0]          done_resp,
    output logic                done_perr,

    output logic                err_vld,
    output logic [ADDR_W-1:0]   err_addr,
    input  logic                err_clr,

    output logic                arvalid_s1,
    input  logic                arready_s1,
    output logic [ADDR_W-1:0]   araddr_s1,
    output logic [7:0]          arid_s1,
    output logic [7:0]          arlen_s1,
    output logic [2:0]          arsize_s1,
    output logic [1:0]          arburst_s1,
    output logic [3:0]          arcache_s1,
    output logic [2:0]          arprot_s1,

    input  logic                rvalid_s1,
    output logic                rready_s1,
    input  logic [127:0]        rdata_s1,
    input  logic [1:0]          rresp_s1,
    input  logic                rlast_s1,
    input  logic [7:0]          rid_s1,

    output logic                awvalid_s1,
    input  logic                awready_s1,
    output logic [ADDR_W-1:0]   awaddr_s1,
    output logic [7:0]          awid_s1,
    output logic [7:0]          awlen_s1,
    output logic [2:0]          awsize_s1,
    output logic [1:0]          awburst_s1,
    output logic [3:0]          awcache_s1,
    output logic [2:0]          awprot_s1,

    output logic                wvalid_s1,
    input  logic                wready_s1,
    output logic [127:0]        wdata_s1,
    output logic [15:0]         wstrb_s1,
    output logic                wlast_s1,
    output logic [7:0]          wid_s1,

    input  logic                bvalid_s1,
    output logic                bready_s1,
    input  logic [1:0]          bresp_s1,
    input  logic [7:0]          bid_s1
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

    state_t       state;
    logic [7:0]   len_q;
    logic [7:0]   cnt;
    logic [1:0]   acc;
    logic         perr;
    logic [7:0]   id_q;

    // Low nibble is masked rather than sliced off so every cmd_addr bit is consumed.
    logic [ADDR_W-1:0] cmd_addr_al;
    assign cmd_addr_al = cmd_addr & ~ADDR_W'(15);

    logic cmd_hs;
    logic r_hs;
    logic w_hs;
    logic b_hs;
    assign cmd_hs = cmd_vld & cmd_rdy;
    assign r_hs   = rvalid_s1 & rready_s1;
    assign w_hs   = wvalid_s1 & wready_s1;
    assign b_hs   = bvalid_s1 & bready_s1;

    // Running worst response and per-beat protocol check on the read stream.
    // A non-last beat at cnt==len flags a late rlast; later beats are still forwarded.
    logic [1:0] r_acc_nxt;
    logic       r_beat_perr;
    assign r_acc_nxt   = (rresp_s1 > acc) ? rresp_s1 : acc;
    assign r_beat_perr = (rid_s1 != AXI_ID)
                       | (rlast_s1 & (cnt < len_q))
                       | (~rlast_s1 & (cnt == len_q));

    // Fixed burst attributes: 16-byte beats, INCR, modifiable/bufferable, unprivileged secure data.
    assign arsize_s1  = 3'b100;
    assign arburst_s1 = 2'b01;
    assign arcache_s1 = 4'b0011;
    assign arprot_s1  = 3'b000;
    assign awsize_s1  = 3'b100;
    assign awburst_s1 = 2'b01;
    assign awcache_s1 = 4'b0011;
    assign awprot_s1  = 3'b000;

    assign arid_s1 = id_q;
    assign awid_s1 = id_q;
    assign wid_s1  = id_q;

    // W channel is a straight passthrough of the write stream while in W.
    assign wvalid_s1 = (state == ST_W) & wdat_vld;
    assign wdat_rdy  = (state == ST_W) & wready_s1;
    assign wlast_s1  = (state == ST_W) & (cnt == len_q);
    assign wdata_s1  = wdat;
    assign wstrb_s1  = wdat_strb;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            cnt        <= '0;
            acc        <= '0;
            perr       <= 1'b0;
            id_q       <= '0;
            cmd_rdy    <= 1'b0;
            arvalid_s1 <= 1'b0;
            araddr_s1  <= '0;
            arlen_s1   <= '0;
            awvalid_s1 <= 1'b0;
            awaddr_s1  <= '0;
            awlen_s1   <= '0;
            rready_s1  <= 1'b0;
            bready_s1  <= 1'b0;
            rdat_vld   <= 1'b0;
            rdat       <= '0;
            rdat_last  <= 1'b0;
            done_vld   <= 1'b0;
            done_resp  <= '0;
            done_perr  <= 1'b0;
        end else begin
            rdat_vld <= 1'b0;
            done_vld <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (cmd_hs) begin
                        cmd_rdy <= 1'b0;
                        len_q   <= cmd_len;
                        cnt     <= '0;
                        acc     <= '0;
                        perr    <= 1'b0;
                        id_q    <= AXI_ID;
                        if (cmd_wr) begin
                            awvalid_s1 <= 1'b1;
                            awaddr_s1  <= cmd_addr_al;
                            awlen_s1   <= cmd_len;
                            state      <= ST_AW;
                        end else begin
                            arvalid_s1 <= 1'b1;
                            araddr_s1  <= cmd_addr_al;
                            arlen_s1   <= cmd_len;
                            state      <= ST_AR;
                        end
                    end
                end

                ST_AR: begin
                    if (arready_s1) begin
                        arvalid_s1 <= 1'b0;
                        rready_s1  <= 1'b1;
                        state      <= ST_R;
                    end
                end

                ST_R: begin
                    if (r_hs) begin
                        rdat      <= rdata_s1;
                        rdat_last <= rlast_s1;
                        rdat_vld  <= 1'b1;
                        cnt       <= cnt + 8'd1;
                        acc       <= r_acc_nxt;
                        perr      <= perr | r_beat_perr;
                        if (rlast_s1) begin
                            rready_s1 <= 1'b0;
                            done_vld  <= 1'b1;
                            done_resp <= r_acc_nxt;
                            done_perr <= perr | r_beat_perr;
                            cmd_rdy   <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end

                ST_AW: begin
                    if (awready_s1) begin
                        awvalid_s1 <= 1'b0;
                        state      <= ST_W;
                    end
                end

                ST_W: begin
                    if (w_hs) begin
                        cnt <= cnt + 8'd1;
                        if (cnt == len_q) begin
                            bready_s1 <= 1'b1;
                            state     <= ST_B;
                        end
                    end
                end

                ST_B: begin
                    if (b_hs) begin
                        bready_s1 <= 1'b0;
                        acc       <= bresp_s1;
                        done_vld  <= 1'b1;
                        done_resp <= bresp_s1;
                        done_perr <= perr | (bid_s1 != AXI_ID);
                        cmd_rdy   <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AXI_MST128_ERR_LOG_EN
    // Keeps the first SLVERR/DECERR start address until software clears it.
    logic [ADDR_W-1:0] start_addr;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            start_addr <= '0;
            err_vld    <= 1'b0;
            err_addr   <= '0;
        end else begin
            if (cmd_hs) begin
                start_addr <= cmd_addr_al;
            end
            // Clear has priority over a same-cycle new error.
            if (err_clr) begin
                err_vld <= 1'b0;
            end else if (done_vld && done_resp[1] && !err_vld) begin
                err_vld  <= 1'b1;
                err_addr <= start_addr;
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_vld  = 1'b0;
    assign err_addr = '0;
`endif

endmodule

// File: tb/tb_axi_mst128_cmd.sv
// Directed bench for axi_mst128_cmd: reset state, read/write bursts, protocol errors, async reset, error log.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled one further unit later.
// Backpressure: AR/AW/W/B stalls are injected by the bench acting as the AXI slave.
module tb_axi_mst128_cmd;

    localparam int ADDR_W = 40;
    localparam logic [7:0] ID = 8'h01;
`ifdef AXI_MST128_ERR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_vld = 0, cmd_rdy, cmd_wr = 0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [7:0]        cmd_len = '0;
    logic              wdat_vld = 0, wdat_rdy;
    logic [127:0]      wdat = '0;
    logic [15:0]       wdat_strb = '0;
    logic              rdat_vld, rdat_last;
    logic [127:0]      rdat;
    logic              done_vld, done_perr;
    logic [1:0]        done_resp;
    logic              err_vld, err_clr = 0;
    logic [ADDR_W-1:0] err_addr;
    logic              arvalid, arready = 0;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arid, arlen;
    logic [2:0]        arsize, arprot;
    logic [1:0]        arburst;
    logic [3:0]        arcache;
    logic              rvalid = 0, rready, rlast = 0;
    logic [127:0]      rdata = '0;
    logic [1:0]        rresp = '0;
    logic [7:0]        rid = '0;
    logic              awvalid, awready = 0;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awid, awlen;
    logic [2:0]        awsize, awprot;
    logic [1:0]        awburst;
    logic [3:0]        awcache;
    logic              wvalid, wready = 0, wlast;
    logic [127:0]      wdata;
    logic [15:0]       wstrb;
    logic [7:0]        wid;
    logic              bvalid = 0, bready;
    logic [1:0]        bresp = '0;
    logic [7:0]        bid = '0;

    int nvec = 0;
    int nerr = 0;

    axi_mst128_cmd #(.ADDR_W(ADDR_W), .AXI_ID(ID)) dut (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdat_vld(wdat_vld), .wdat_rdy(wdat_rdy), .wdat(wdat), .wdat_strb(wdat_strb),
        .rdat_vld(rdat_vld), .rdat(rdat), .rdat_last(rdat_last),
        .done_vld(done_vld), .done_resp(done_resp), .done_perr(done_perr),
        .err_vld(err_vld), .err_addr(err_addr), .err_clr(err_clr),
        .arvalid_s1(arvalid), .arready_s1(arready), .araddr_s1(araddr), .arid_s1(arid), .arlen_s1(arlen),
        .arsize_s1(arsize), .arburst_s1(arburst), .arcache_s1(arcache), .arprot_s1(arprot),
        .rvalid_s1(rvalid), .rready_s1(rready), .rdata_s1(rdata), .rresp_s1(rresp), .rlast_s1(rlast), .rid_s1(rid),
        .awvalid_s1(awvalid), .awready_s1(awready), .awaddr_s1(awaddr), .awid_s1(awid), .awlen_s1(awlen),
        .awsize_s1(awsize), .awburst_s1(awburst), .awcache_s1(awcache), .awprot_s1(awprot),
        .wvalid_s1(wvalid), .wready_s1(wready), .wdata_s1(wdata), .wstrb_s1(wstrb), .wlast_s1(wlast), .wid_s1(wid),
        .bvalid_s1(bvalid), .bready_s1(bready), .bresp_s1(bresp), .bid_s1(bid)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic wr, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        int k = 0;
        while (!cmd_rdy && k < 50) begin
            tick();
            k++;
        end
        check("cmd_rdy_wait", cmd_rdy, 1'b1);
        cmd_vld = 1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
        tick();
        cmd_vld = 0;
        check("cmd_rdy_drop", cmd_rdy, 1'b0);
    endtask

    // Read: AR stalled one cycle, then nbeats R beats (data base+i, resp from 2-bit pattern slots).
    task automatic rd_txn(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input int nbeats,
                          input logic [7:0] id, input logic [15:0] resp_pat, input logic [127:0] base,
                          input bit gap, input logic [ADDR_W-1:0] exp_addr,
                          input logic [1:0] exp_resp, input logic exp_perr);
        do_cmd(1'b0, addr, len);
        check("arvalid_up", arvalid, 1'b1);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, len);
        check("arid", arid, ID);
        check("ar_attr", {arsize, arburst, arcache, arprot}, {3'b100, 2'b01, 4'b0011, 3'b000});
        tick();
        check("arvalid_hold", arvalid, 1'b1);
        arready = 1;
        tick();
        arready = 0;
        check("arvalid_drop", arvalid, 1'b0);
        check("rready_up", rready, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1; rdata = base + 128'(i); rlast = (i == nbeats - 1); rid = id;
            rresp = resp_pat[2*(i%8) +: 2];
            tick();
            rvalid = 0; rlast = 0;
            check("rdat_vld", rdat_vld, 1'b1);
            check("rdat", rdat, base + 128'(i));
            check("rdat_last", rdat_last, (i == nbeats - 1));
            if (i != nbeats - 1) begin
                check("done_early", done_vld, 1'b0);
                if (gap) begin
                    tick();
                    check("rdat_vld_gap", rdat_vld, 1'b0);
                end
            end
        end
        check("rd_done_vld", done_vld, 1'b1);
        check("rd_done_resp", done_resp, exp_resp);
        check("rd_done_perr", done_perr, exp_perr);
        check("rd_cmd_rdy", cmd_rdy, 1'b1);
        check("rready_drop", rready, 1'b0);
    endtask

    // Write: AW accepted after one stall, len+1 beats under random wready, B stalled one cycle.
    task automatic wr_txn(input logic [ADDR_W-1:0] addr, input logic [7:0] len, input logic [1:0] br,
                          input logic [7:0] id_b, input logic [ADDR_W-1:0] exp_addr, input logic exp_perr);
        do_cmd(1'b1, addr, len);
        check("awvalid_up", awvalid, 1'b1);
        check("awaddr", awaddr, exp_addr);
        check("awlen", awlen, len);
        check("awid", awid, ID);
        check("aw_attr", {awsize, awburst, awcache, awprot}, {3'b100, 2'b01, 4'b0011, 3'b000});
        tick();
        check("awvalid_hold", awvalid, 1'b1);
        awready = 1;
        tick();
        awready = 0;
        check("awvalid_drop", awvalid, 1'b0);
        for (int b = 0; b <= int'(len); b++) begin
            bit hs = 0;
            wdat_vld = 1;
            wdat = {4{32'hC0DE_0000 + 32'(b)}};
            wdat_strb = 16'hFFFF ^ 16'(b);
            for (int k = 0; k < 20 && !hs; k++) begin
                wready = (k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                check("wvalid", wvalid, 1'b1);
                check("wlast", wlast, (b == int'(len)));
                check("wdat_rdy", wdat_rdy, wready);
                if (wready) begin
                    check("wdata", {wdata, wstrb, wid}, {wdat, wdat_strb, ID});
                    hs = 1;
                end
                @(posedge clk);
                #1;
            end
        end
        wdat_vld = 0; wready = 0;
        check("wvalid_idle", wvalid, 1'b0);
        check("bready_up", bready, 1'b1);
        tick();
        check("wr_no_done", done_vld, 1'b0);
        bvalid = 1; bresp = br; bid = id_b;
        tick();
        bvalid = 0;
        check("wr_done_vld", done_vld, 1'b1);
        check("wr_done_resp", done_resp, br);
        check("wr_done_perr", done_perr, exp_perr);
        check("bready_drop", bready, 1'b0);
        check("wr_cmd_rdy", cmd_rdy, 1'b1);
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check("rst_hs", {cmd_rdy, wdat_rdy, rdat_vld, done_vld, done_perr, err_vld}, 6'b0);
        check("rst_resp", done_resp, 2'b00);
        check("rst_addr", {araddr, awaddr}, 80'h0);
        check("rst_len_id", {arlen, awlen, arid, awid, wid}, 40'h0);
        tick();
        rst_b = 1;
        tick();
        check("cmd_rdy_after_rst", cmd_rdy, 1'b1);

        // Single-beat read, OKAY
        rd_txn(40'h1000, 8'd0, 1, ID, 16'h0000, {16{8'hA5}}, 0, 40'h1000, 2'b00, 1'b0);

        // Four-beat write to 0x2030, EXOKAY response
        wr_txn(40'h2030, 8'd3, 2'b01, ID, 40'h2030, 1'b0);

        // Four-beat SLVERR read, unaligned start address masked to 0x3000
        rd_txn(40'h3004, 8'd3, 4, ID, 16'hAAAA, 128'h0, 1, 40'h3000, 2'b10, 1'b0);
        check("err_not_yet", err_vld, 1'b0);
        tick();
        check("err_vld_set", err_vld, LOG);
        check("err_addr", err_addr, LOG ? 40'h3000 : 40'h0);

        // Wrong RID
        rd_txn(40'h5000, 8'd1, 2, 8'h02, 16'h0000, 128'h11, 0, 40'h5000, 2'b00, 1'b1);
        // Early RLAST on beat 2 of 4
        rd_txn(40'h6000, 8'd3, 2, ID, 16'h0000, 128'h22, 0, 40'h6000, 2'b00, 1'b1);
        // Late RLAST: len=1 but three beats, all forwarded
        rd_txn(40'h7000, 8'd1, 3, ID, 16'h0000, 128'h33, 1, 40'h7000, 2'b00, 1'b1);
        // Mixed responses OKAY/EXOKAY/OKAY -> worst is EXOKAY
        rd_txn(40'h8000, 8'd2, 3, ID, 16'h0004, 128'h44, 0, 40'h8000, 2'b01, 1'b0);
        // 256-beat read, no wrap error
        rd_txn(40'h9000, 8'd255, 256, ID, 16'h0000, 128'h100, 0, 40'h9000, 2'b00, 1'b0);
        check("err_kept", err_vld, LOG);

        // Clear log, then clear in the same cycle as a new DECERR completion
        err_clr = 1;
        tick();
        err_clr = 0;
        check("err_cleared", err_vld, 1'b0);
        rd_txn(40'h4010, 8'd0, 1, ID, 16'h0003, 128'h55, 0, 40'h4010, 2'b11, 1'b0);
        err_clr = 1;
        tick();
        err_clr = 0;
        check("err_clr_wins", err_vld, 1'b0);

        // Async reset in the middle of a write burst
        do_cmd(1'b1, 40'hA000, 8'd3);
        awready = 1;
        tick();
        awready = 0;
        wdat_vld = 1; wready = 1; wdat = 128'h77;
        tick();
        wready = 0;
        check("mid_wvalid", wvalid, 1'b1);
        wready = 1;
        rst_b = 0;
        #1;
        check("arst_valids", {arvalid, awvalid, wvalid, bready, rready, wdat_rdy}, 6'b0);
        check("arst_done", done_vld, 1'b0);
        wdat_vld = 0; wready = 0;
        tick();
        tick();
        check("arst_no_done", done_vld, 1'b0);
        rst_b = 1;
        tick();
        check("arst_cmd_rdy", cmd_rdy, 1'b1);
        wr_txn(40'hB000, 8'd1, 2'b00, ID, 40'hB000, 1'b0);
        // Wrong BID
        wr_txn(40'hC000, 8'd0, 2'b10, 8'h07, 40'hC000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
